// File: rtl/btn_event_gen_pkg.sv
// Shared sizing helpers for the button event generator.
package btn_event_gen_pkg;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit of headroom above the widest terminal count.
  function automatic int unsigned cnt_width(input int unsigned long_cycles,
                                            input int unsigned repeat_cycles);
    return $clog2(max_u(long_cycles, repeat_cycles)) + 1;
  endfunction

endpackage

// File: rtl/btn_event_gen.sv
// Button event generator: press/release/long/auto-repeat strobes and a held level,
// all registered, from a debounced clk-synchronous button level.
module btn_event_gen
  import btn_event_gen_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  // The counter reads N-1 during the cycle whose edge must emit the N-th strobe.
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          prev_q;
  logic          press_d, release_d, long_d, repeat_d, held_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_inc;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = held_q_sig();

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_level && !prev_q) begin
          state_d = PRESS;
          press_d = 1'b1;
          held_d  = 1'b1;
        end
      end
      PRESS: begin
        // Release is tested first so it wins over a coincident expiry.
        if (!btn_level) begin
          state_d   = IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      LONG: begin
        if (!btn_level) begin
          state_d   = IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  function automatic logic held_q_sig();
    return held;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      prev_q        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_q        <= btn_level;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Self-checking bench for btn_event_gen against a hold-length reference model.
module tb_btn_event_gen;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_level;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic [4:0] obs;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: edges elapsed since the press edge decide every strobe.
  bit         m_held;
  int         m_k;
  logic [4:0] exp_vec;

  btn_event_gen #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  assign obs = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};

  function automatic void model_reset();
    m_held  = 1'b0;
    m_k     = 0;
    exp_vec = '0;
  endfunction

  // exp_vec = {press, release, long, repeat, held}
  function automatic void model_sample(input logic s);
    exp_vec = '0;
    if (s) begin
      if (!m_held) begin
        m_held     = 1'b1;
        m_k        = 0;
        exp_vec[4] = 1'b1;
      end else begin
        m_k++;
        if (m_k == L) exp_vec[2] = 1'b1;
        else if (m_k > L && (m_k - L) % R == 0) exp_vec[1] = 1'b1;
      end
    end else if (m_held) begin
      m_held     = 1'b0;
      exp_vec[3] = 1'b1;
    end
    exp_vec[0] = m_held;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_sample(btn_level);
    #1;
  endtask

  task automatic step(input logic b);
    @(negedge clk);
    btn_level = b;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_level = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_compared++;
    if (obs !== exp_vec) begin
      n_mismatched++;
      $display("FAIL reset_state: got %b want %b", obs, exp_vec);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_compared++;
    if (obs !== exp_vec) begin
      n_mismatched++;
      $display("FAIL reset_release_press: got %b want %b", obs, exp_vec);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      n_compared++;
      if (obs !== exp_vec) begin
        n_mismatched++;
        $display("FAIL reset_then_release cyc %0d: got %b want %b", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_short_press();
    for (int i = 0; i < 6; i++) begin
      step(i < 3);
      n_compared++;
      if (obs !== exp_vec) begin
        n_mismatched++;
        $display("FAIL short_press cyc %0d: got %b want %b", i + 1, obs, exp_vec);
      end
    end
  endtask

  task automatic test_long_hold();
    int press_idx = -1;
    int long_idx  = -1;
    int rep_idx[$];
    for (int i = 0; i < 24; i++) begin
      step(i < 20);
      if (press_pulse === 1'b1) press_idx = i;
      if (long_pulse === 1'b1) long_idx = i;
      if (repeat_pulse === 1'b1) rep_idx.push_back(i);
      n_compared++;
      if (obs !== exp_vec) begin
        n_mismatched++;
        $display("FAIL long_hold cyc %0d: got %b want %b", i + 1, obs, exp_vec);
      end
    end
    n_compared++;
    if (long_idx - press_idx !== L) begin
      n_mismatched++;
      $display("FAIL long_latency: got %0d want %0d", long_idx - press_idx, L);
    end
    n_compared++;
    if (rep_idx.size() !== 2) begin
      n_mismatched++;
      $display("FAIL repeat_count: got %0d want 2", rep_idx.size());
    end else begin
      n_compared++;
      if (rep_idx[0] - long_idx !== R || rep_idx[1] - long_idx !== 2 * R) begin
        n_mismatched++;
        $display("FAIL repeat_spacing: got +%0d,+%0d want +%0d,+%0d",
                 rep_idx[0] - long_idx, rep_idx[1] - long_idx, R, 2 * R);
      end
    end
  endtask

  task automatic test_collision();
    bit saw_long = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step(i < L);
      if (long_pulse === 1'b1) saw_long = 1'b1;
      n_compared++;
      if (obs !== exp_vec) begin
        n_mismatched++;
        $display("FAIL collision cyc %0d: got %b want %b", i + 1, obs, exp_vec);
      end
    end
    n_compared++;
    if (saw_long !== 1'b0) begin
      n_mismatched++;
      $display("FAIL collision_long_seen: got %b want 0", saw_long);
    end
  endtask

  task automatic test_glitch();
    int held_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      step(i == 0);
      if (held === 1'b1) held_cycles++;
      n_compared++;
      if (obs !== exp_vec) begin
        n_mismatched++;
        $display("FAIL glitch cyc %0d: got %b want %b", i + 1, obs, exp_vec);
      end
    end
    n_compared++;
    if (held_cycles !== 1) begin
      n_mismatched++;
      $display("FAIL glitch_held_len: got %0d want 1", held_cycles);
    end
  endtask

  task automatic test_reset_mid_long();
    for (int i = 0; i < 14; i++) step(1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_compared++;
    if (obs !== exp_vec) begin
      n_mismatched++;
      $display("FAIL reset_mid_long_async: got %b want %b", obs, exp_vec);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_compared++;
      if (obs !== exp_vec) begin
        n_mismatched++;
        $display("FAIL reset_mid_long_hold cyc %0d: got %b want %b", i, obs, exp_vec);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_compared++;
    if (obs !== exp_vec) begin
      n_mismatched++;
      $display("FAIL reset_mid_long_repress: got %b want %b", obs, exp_vec);
    end
    for (int i = 0; i < 4; i++) begin
      step(i < 2);
      n_compared++;
      if (obs !== exp_vec) begin
        n_mismatched++;
        $display("FAIL reset_mid_long_tail cyc %0d: got %b want %b", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    logic lvl = 1'($urandom_range(0, 1));
    for (int run = 0; run < 40; run++) begin
      int len = (run % 3 == 0) ? int'($urandom_range(L - 1, L + 3 * R + 1))
                               : int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        step(lvl);
        n_compared++;
        if (obs !== exp_vec) begin
          n_mismatched++;
          $display("FAIL random run %0d cyc %0d: got %b want %b", run, i, obs, exp_vec);
        end
        n_compared++;
        if ($countones(obs[4:1]) > 1) begin
          n_mismatched++;
          $display("FAIL strobe_onehot run %0d cyc %0d: got %b want at most one", run, i, obs[4:1]);
        end
      end
      lvl = ~lvl;
    end
    step(1'b0);
    n_compared++;
    if (obs !== exp_vec) begin
      n_mismatched++;
      $display("FAIL random_tail: got %b want %b", obs, exp_vec);
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_hold();
    test_collision();
    test_glitch();
    test_reset_mid_long();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/btn_event_gen.md
BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 Parameter LONG_CYCLES, default 50000000, hold cycles from press_pulse to long_pulse (0.5 s at 100 MHz); legal range >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 10000000, cycles between successive repeat_pulse events; legal range >= 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 btn_level  input  1  debounced, clk-synchronous button level; 1 = pressed.
REQ-006 press_pulse  output  1  one-cycle strobe on press.
REQ-007 release_pulse  output  1  one-cycle strobe on release.
REQ-008 long_pulse  output  1  one-cycle strobe when the button has been held LONG_CYCLES.
REQ-009 repeat_pulse  output  1  one-cycle auto-repeat strobe while the button remains held after long_pulse.
REQ-010 held  output  1  level, 1 from press_pulse until release_pulse.

Function
REQ-011 All outputs SHALL be registered; there is no combinational path from btn_level to any output.
REQ-012 The state machine SHALL have three states: IDLE, PRESS (held, before long), LONG (held, auto-repeating).
REQ-013 IDLE->PRESS on a 0->1 edge of btn_level; press_pulse=1 and held=1 in the cycle after the edge at which btn_level is first sampled 1.
REQ-014 In PRESS, a cycle counter SHALL clear on entry; long_pulse SHALL fire exactly LONG_CYCLES cycles after press_pulse; on long_pulse the state changes to LONG and the counter clears.
REQ-015 In LONG, repeat_pulse SHALL fire every REPEAT_CYCLES cycles, the first one REPEAT_CYCLES cycles after long_pulse.
REQ-016 PRESS or LONG -> IDLE when btn_level is sampled 0; release_pulse=1 and held=0 in the following cycle; the counter clears.
REQ-017 A release sampled in the same cycle as a counter expiry SHALL take priority: release_pulse fires and long_pulse/repeat_pulse do not.
REQ-018 At most one of press_pulse, release_pulse, long_pulse, repeat_pulse SHALL be high in any cycle.
REQ-019 A one-cycle press (1 then 0) SHALL produce press_pulse followed by release_pulse on the next cycle.
REQ-020 Counter width SHALL be clog2(max(LONG_CYCLES, REPEAT_CYCLES))+1 bits; the counter saturates and never wraps.
REQ-021 Auto-repeat SHALL continue indefinitely while held; there is no repeat limit.

Reset
REQ-022 While rst=1: state=IDLE, counter=0, all outputs 0, and the previous-sample register=0.
REQ-023 If btn_level=1 when rst deasserts, press_pulse SHALL fire on the first active cycle (the previous-sample register resets to 0).
REQ-024 Reset asserted mid-press SHALL abort without emitting release_pulse.

Structure
REQ-025 State encodings SHALL be local constants; no shared package is required because no type is used outside this module.
REQ-026 Single module, no sub-modules; the edge detector, counter and FSM are implemented inline.

Verification (bench parameters: LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-027 Short press: btn_level high for 3 cycles. Required: press_pulse at cycle 1, held high for 3 cycles, release_pulse at cycle 4, no long_pulse.
REQ-028 Long hold: btn_level high for 20 cycles. Required: long_pulse 8 cycles after press_pulse, repeat_pulse at +4 and +8 after long_pulse, then release_pulse.
REQ-029 Collision: release exactly on the long-expiry cycle (hold 8). Required: release_pulse only, long_pulse never asserted.
REQ-030 Glitch: one-cycle high. Required: press_pulse, then release_pulse on the next cycle, held high for exactly 1 cycle.
REQ-031 Reset mid-LONG: assert rst during auto-repeat. Required: all outputs 0 immediately, no release_pulse; with btn_level still 1 at deassert, press_pulse on the first active cycle.
REQ-032 Every scenario: checker confirms at most one strobe per cycle.
